instr_prefetch_unit: RTL and testbench
======================================

# instr_prefetch_unit

Instruction prefetch unit between instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues sequential fetch requests over a valid/ready request channel. In-order responses are queued with their PC in a DEPTH-entry buffer. The buffer is held under hazard stalls and discarded on branch redirects, including responses still in flight.

## Interface
- ADDR_WIDTH, 32, PC / fetch address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, buffer entries (power of two, ≥2); also max requests in flight
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_WIDTH  fetch address (word aligned)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; exactly one per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction
- redirect  in  1  taken-branch / mispredict flush
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- stall  in  1  hazard stall: downstream does not consume
- out_valid  out  1  out_pc/out_instr hold a valid instruction
- out_pc  out  ADDR_WIDTH  PC of presented instruction
- out_instr  out  INSTR_WIDTH  presented instruction; 0 when out_valid=0

## Operation
- State: fetch_pc; circular buffer of DEPTH entries {pc, instr, filled}; alloc/fill/head pointers; occupancy count occ (0..DEPTH); discard count dsc (0..DEPTH).
- Issue: imem_req_valid = !redirect && (occ + dsc < DEPTH). imem_req_addr = fetch_pc.
- On valid&ready: allocate entry at alloc pointer with pc=fetch_pc, filled=0; fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH.
- Response when dsc>0: dropped, dsc decrements.
- Response when dsc=0: writes instr to entry at fill pointer, sets filled, fill pointer advances.
- Output: out_valid = head entry allocated && filled; out_pc/out_instr from head.
- Pop: when out_valid && !stall, head advances and occ decrements.
- stall=1: head entry and outputs held unchanged; issue continues until the buffer is full.
- Redirect: all entries cleared (occ=0, pointers equal) and fetch_pc ← redirect_pc. dsc ← dsc + (allocated-unfilled count) − (imem_rsp_valid ? 1 : 0). Any response in the redirect cycle is dropped.
- Simultaneous events:
  - redirect beats stall and pop.
  - reset beats redirect.
  - Allocate and pop in the same cycle: occ unchanged.
  - Full (occ + dsc = DEPTH): no request issued, responses still accepted.
- Pointer wrap-around modulo DEPTH is required; full/empty are derived from occ, never from pointer equality alone.

## Timing
- Reset (cycle with reset=1):
  - fetch_pc=RESET_PC, occ=0, dsc=0, all filled=0.
  - out_valid=0, out_pc=0, out_instr=0, imem_req_valid=0.
- First cycle after reset: imem_req_valid=1, imem_req_addr=RESET_PC.
- Response latency: imem_rsp_valid in cycle N makes out_valid=1 in cycle N+1 at the earliest (head entry).
- Sustained throughput: one instruction per cycle with 1-cycle memory, ready=1, stall=0.
- Redirect in cycle N:
  - Cycle N+1: out_valid=0, imem_req_valid=1 (if dsc < DEPTH), imem_req_addr=redirect_pc.
  - First new-stream instruction appears no earlier than 2 cycles after its request is accepted.
- Reset mid-operation: all in-flight responses are forgotten. The memory side is reset together with this block.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr-derived data, stall=0 -> requests 0x0,0x4,0x8,… on consecutive cycles; out_pc 0x0 valid 2 cycles after reset release, then one instruction per cycle in order.
- stall=1 for 6 cycles, DEPTH=4 -> out_pc frozen, exactly 4 entries buffered, imem_req_valid=0 once full; on stall release, 4 sequential PCs drain back-to-back.
- Memory with 3-cycle latency, 3 requests in flight, redirect to 0x100 -> the 3 old responses are dropped; first out_pc after redirect = 0x100 with the correct instruction; no stale PC ever valid.
- Redirect in the same cycle as imem_rsp_valid and stall=1 -> that response dropped, outputs cleared next cycle, dsc accounts correctly, next fetch addr = redirect_pc.
- imem_req_ready toggling 1/0 randomly -> fetch_pc advances only on accepted requests; out_pc sequence strictly +4 with no gaps or duplicates.
- fetch_pc at 0xFFFFFFFC -> next request addr 0x00000000; reset asserted mid-stream -> next cycle all outputs 0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_prefetch_unit_if
// Instruction-memory fetch channel between the prefetch unit and imem.
//   imem_req_valid  fetch request valid            (prefetch -> imem)
//   imem_req_addr   word-aligned fetch address      (prefetch -> imem)
//   imem_req_ready  memory accepts the request      (imem -> prefetch)
//   imem_rsp_valid  in-order response valid         (imem -> prefetch)
//   imem_rsp_data   fetched instruction             (imem -> prefetch)
// Modports: master = prefetch unit side, slave = instruction memory side.
// ----------------------------------------------------------------------------
interface instr_prefetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_req_ready;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_prefetch_unit.sv
// ----------------------------------------------------------------------------
// instr_prefetch_unit
// Owns the fetch PC, issues sequential fetch requests to instruction memory
// and queues in-order responses with their PC in a DEPTH-entry circular
// buffer feeding the IF/ID register. The buffer is held under stall and
// flushed on redirect; responses to flushed requests are dropped as they
// return.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem (master)         fetch request / response channel
//   redirect, redirect_pc taken-branch flush and new fetch PC
//   stall                 downstream does not consume this cycle
//   out_valid/out_pc/out_instr  head instruction presented downstream
// ----------------------------------------------------------------------------
module instr_prefetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_unit_if.master  imem,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   stall,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  buf_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] buf_instr [DEPTH];
    logic [DEPTH-1:0]       buf_filled;

    ptr_t alloc_ptr;
    ptr_t fill_ptr;
    ptr_t head_ptr;

    // occ: allocated entries; dsc: responses still owed to flushed requests;
    // pend: allocated entries still waiting for their response.
    cnt_t occ;
    cnt_t dsc;
    cnt_t pend;

    logic         issue;
    logic         accept;
    logic         pop;
    logic         fill;
    logic         drop;
    logic [CNT_W:0] committed;
    logic         head_valid;

    always_comb begin
        committed  = {1'b0, occ} + {1'b0, dsc};
        issue      = !reset && !redirect && (committed < {1'b0, DEPTH_C});
        accept     = issue && imem.imem_req_ready;
        head_valid = (occ != '0) && buf_filled[head_ptr];
        out_valid  = !reset && head_valid;
        pop        = out_valid && !stall && !redirect;
        // A response belongs to a flushed request while dsc is nonzero,
        // because memory answers strictly in order.
        fill       = imem.imem_rsp_valid && !redirect && (dsc == '0) && (pend != '0);
        drop       = imem.imem_rsp_valid && !redirect && (dsc != '0);
        out_pc     = out_valid ? buf_pc[head_ptr]    : '0;
        out_instr  = out_valid ? buf_instr[head_ptr] : '0;
    end

    assign imem.imem_req_valid = issue;
    assign imem.imem_req_addr  = fetch_pc;

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            occ        <= '0;
            dsc        <= '0;
            pend       <= '0;
            buf_filled <= '0;
        end else if (redirect) begin
            fetch_pc   <= redirect_pc;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            occ        <= '0;
            pend       <= '0;
            buf_filled <= '0;
            // Every still-pending request now owes a response that must be
            // dropped; a response arriving this very cycle pays one off.
            if (imem.imem_rsp_valid && ((dsc + pend) != '0)) begin
                dsc <= dsc + pend - cnt_t'(1);
            end else begin
                dsc <= dsc + pend;
            end
        end else begin
            if (accept) begin
                buf_filled[alloc_ptr] <= 1'b0;
                alloc_ptr             <= alloc_ptr + ptr_t'(1);
                fetch_pc              <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (fill) begin
                buf_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + ptr_t'(1);
            end
            if (drop) begin
                dsc <= dsc - cnt_t'(1);
            end
            if (pop) begin
                buf_filled[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + ptr_t'(1);
            end
            occ  <= occ + cnt_t'(accept) - cnt_t'(pop);
            pend <= pend + cnt_t'(accept) - cnt_t'(fill);
        end
    end

    // Buffer payload; only qualified by buf_filled, so no reset needed.
    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            if (accept) begin
                buf_pc[alloc_ptr] <= fetch_pc;
            end
            if (fill) begin
                buf_instr[fill_ptr] <= imem.imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_unit
// Randomised bench for instr_prefetch_unit. A memory model answers accepted
// requests in order after a random latency with address-derived data. A
// reference model tracks the program-order stream as a queue of expected
// {pc, instr}; a monitor compares what the DUT presents against its front.
// Ports of the DUT: clk, reset, imem interface, redirect/redirect_pc, stall,
// out_valid/out_pc/out_instr.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RST_PC = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          stall;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;

    instr_prefetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) mem_if ();

    instr_prefetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (mem_if),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   epoch;
        int unsigned   due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;
    int unsigned last_due = 0;
    int unsigned epoch   = 0;
    int unsigned cur_rsp_epoch = 0;
    int unsigned nfilled = 0;
    int unsigned ready_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [AW-1:0] model_pc = RST_PC;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = {a[15:0], a[31:16]};
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Instruction memory: in-order responses, random latency and readiness.
    initial begin
        mreq_t it;
        mem_if.imem_req_ready = 1'b0;
        mem_if.imem_rsp_valid = 1'b0;
        mem_if.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_if.imem_req_ready = ($urandom_range(99) < ready_pct);
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                it = mem_q.pop_front();
                mem_if.imem_rsp_valid = 1'b1;
                mem_if.imem_rsp_data  = instr_of(it.addr);
                cur_rsp_epoch         = it.epoch;
            end else begin
                mem_if.imem_rsp_valid = 1'b0;
                mem_if.imem_rsp_data  = $urandom;
            end
        end
    end

    // Request side: check issue decision, then update the reference model.
    initial begin
        int unsigned dead;
        int unsigned due;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                check("rst_req_valid", 32'(mem_if.imem_req_valid), 32'd0);
            end else begin
                dead = 0;
                foreach (mem_q[i]) if (mem_q[i].epoch != epoch) dead++;
                if (mem_if.imem_rsp_valid && cur_rsp_epoch != epoch) dead++;
                check("req_valid", 32'(mem_if.imem_req_valid),
                      32'(!redirect && ((exp_q.size() + dead) < DEPTH)));
                if (mem_if.imem_req_valid) check("req_addr", mem_if.imem_req_addr, model_pc);
            end
            #2;
            if (reset) begin
                exp_q.delete();
                mem_q.delete();
                nfilled  = 0;
                model_pc = RST_PC;
                epoch++;
                last_due = cyc;
            end else if (redirect) begin
                exp_q.delete();
                nfilled  = 0;
                model_pc = redirect_pc;
                epoch++;
            end else begin
                if (mem_if.imem_rsp_valid && cur_rsp_epoch == epoch) nfilled++;
                if (mem_if.imem_req_valid && mem_if.imem_req_ready) begin
                    exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{addr: mem_if.imem_req_addr, epoch: epoch, due: due});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    // Output monitor: compares the presented instruction with the model front.
    initial begin
        exp_t  e;
        logic  ev;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_pc", out_pc, 32'd0);
                check("rst_out_instr", out_instr, 32'd0);
            end else begin
                ev = (exp_q.size() > 0) && (nfilled > 0);
                check("out_valid", 32'(out_valid), 32'(ev));
                if (ev) begin
                    e = exp_q[0];
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    if (!stall && !redirect) begin
                        void'(exp_q.pop_front());
                        nfilled--;
                    end
                end else begin
                    check("idle_out_instr", out_instr, 32'd0);
                end
            end
        end
    end

    task automatic run(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc, input logic with_stall);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = pc;
        stall       = with_stall;
        @(negedge clk);
        redirect    = 1'b0;
        stall       = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        run(3);
        reset = 1'b0;

        // Streaming with a 1-cycle memory
        run(20);

        // Stall long enough to fill the buffer, then drain
        stall = 1'b1;
        run(6);
        stall = 1'b0;
        run(10);

        // Longer latency with flush while requests are in flight
        lat_min = 3;
        lat_max = 3;
        run(8);
        do_redirect(32'h0000_0100, 1'b0);
        run(15);

        // Redirect together with stall, several attempts to hit a response
        for (int k = 0; k < 4; k++) begin
            run(k + 2);
            do_redirect(32'h0000_0200 + 32'(k) * 32'h40, 1'b1);
        end
        run(12);

        // Random readiness
        lat_min   = 1;
        lat_max   = 2;
        ready_pct = 50;
        run(40);

        // Fetch address wrap-around
        ready_pct = 100;
        lat_min   = 1;
        lat_max   = 1;
        do_redirect(32'hFFFF_FFF8, 1'b0);
        run(10);

        // Reset in the middle of a stream
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(10);

        // Random mix
        for (int s = 0; s < 15; s++) begin
            ready_pct = (s % 3 == 0) ? 100 : ((s % 3 == 1) ? 70 : 40);
            lat_max   = 1 + (s % 4);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                reset       = ($urandom_range(499) == 0);
                stall       = ($urandom_range(3) == 0);
                redirect    = ($urandom_range(24) == 0);
                redirect_pc = (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_1000)
                              + (32'($urandom_range(63)) << 2);
            end
        end
        @(negedge clk);
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
